// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Sequences data-memory wait states, load-use bubbles and syscall halt/resume,
// and counts non-halted cycles for the display.
// Optional feature macro: PIPE_STALL_STATS_EN adds the stall_cnt output.
module pipe_stall_ctrl #(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned WCNT_W  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        load_use,
   input  logic        syscall_halt,
   input  logic        go,
   output logic        mem_en,
   output logic        stall_front,
   output logic        bubble_idex,
   output logic        stall_back,
   output logic        halted,
   output logic [31:0] cycle_cnt
`ifdef PIPE_STALL_STATS_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned       CNT_W     = 32;
   localparam logic              MULTI     = (MEM_LAT > 32'd1);
   localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MEM_LAT - 32'd1);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              skip_q, skip_d;
   logic              sys;
   logic              mstall;

   // State, wait counter and syscall-mask registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         wcnt_q  <= '0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         skip_q  <= skip_d;
      end
   end

   // Next-state and Mealy outputs; everything forced low while reset is held
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      skip_d      = skip_q;
      sys         = 1'b0;
      mstall      = 1'b0;
      mem_en      = 1'b0;
      stall_front = 1'b0;
      bubble_idex = 1'b0;
      stall_back  = 1'b0;
      halted      = 1'b0;
      if (rst) begin
         sys    = syscall_halt & ~skip_q;
         mstall = (state_q == RUN) & mem_req & ~sys & MULTI;
         unique case (state_q)
            RUN: begin
               if (sys) begin
                  state_d = HALT;
               end else if (mstall) begin
                  state_d = MEM_WAIT;
                  wcnt_d  = WCNT_LOAD;
               end
               stall_back  = sys | mstall;
               bubble_idex = ~sys & ~mstall & load_use;
               mem_en      = mem_req & ~sys;
            end
            MEM_WAIT: begin
               if (wcnt_q > WCNT_ONE) begin
                  wcnt_d = wcnt_q - WCNT_ONE;
               end else begin
                  state_d = RUN;
               end
               stall_back = (wcnt_q > WCNT_ONE);
               mem_en     = mem_req;
            end
            HALT: begin
               stall_back = 1'b1;
               halted     = 1'b1;
               if (go) begin
                  state_d = RUN;
                  skip_d  = 1'b1;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
         stall_front = stall_back | bubble_idex;
         // Back end advanced past the serviced syscall
         if (!stall_back) begin
            skip_d = 1'b0;
         end
      end
   end

   // Non-halted cycle counter, wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
      end else if (state_q != HALT) begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
   end

`ifdef PIPE_STALL_STATS_EN
   // Front-end stall cycle counter, excluding halted cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall_front && (state_q != HALT)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
